fx2_packet_reader: RTL and testbench

- Read-side consumer of the multi-channel rx sample FIFO, running in the USB clock domain.
- Waits for the FIFO's packet_rdy, pulls exactly one packet of PACKET_WORDS 16-bit words using rd_req/din, and forwards them to the FX2 slave-FIFO write interface (fd/slwr) under FX2 full backpressure.
- Replaces the behavioural FX2 emulator with synthesizable logic at the other end of the FIFO read protocol.

---
 rtl/fx2_packet_reader.sv | 125 ++++++++++++
 tb/tb_fx2_packet_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_packet_reader.sv
// Reads one packet at a time from the rx sample FIFO and forwards each
// word to the FX2 slave-FIFO write port. A two-entry skid buffer hides
// the one-cycle FIFO read latency, so transfer runs at one word per
// cycle while the FX2 endpoint accepts data, and stalls cleanly on
// fx2_full without losing or repeating words.
module fx2_packet_reader #(
    parameter int PACKET_WORDS = 256,
    parameter int WIDTH        = 16,
    parameter int CNT_W        = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             packet_rdy,
    output logic             rd_req,
    input  logic [WIDTH-1:0] din,
    input  logic             fx2_full,
    output logic [WIDTH-1:0] fd,
    output logic             slwr,
    output logic             busy,
    output logic             pkt_done,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [CNT_W-1:0] PW_C = CNT_W'(PACKET_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] skid_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;
    logic             inflight_q;
    logic [CNT_W-1:0] req_cnt_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [WIDTH-1:0] fd_q;

    logic             in_read;
    logic             pop;
    logic [2:0]       commit;
    logic [1:0]       occ_d;
    logic [CNT_W-1:0] word_cnt_d;
    logic [WIDTH-1:0] fd_d;

    // Pop/request decisions; reset suppresses strobes in the reset cycle itself.
    // commit counts words already owned by the buffer (stored or in flight)
    // after this cycle's pop, so a new read is only issued when it has a slot.
    always_comb begin
        in_read    = (state_q == ST_READ) && !reset;
        pop        = in_read && (occ_q != 2'd0) && !fx2_full;
        commit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_req     = in_read && (req_cnt_q < PW_C) && (commit < 3'd2);
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        word_cnt_d = word_cnt_q + CNT_W'(pop);
        fd_d       = pop ? skid_q[rd_ptr_q] : fd_q;
    end

    assign slwr     = pop;
    assign fd       = fd_d;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_done = (state_q == ST_DONE);
    assign word_cnt = word_cnt_q;

    // Skid buffer storage: capture din in the cycle its read is in flight.
    always_ff @(posedge clk) begin
        if (!reset && inflight_q) begin
            skid_q[wr_ptr_q] <= din;
        end
    end

    // Packet FSM together with buffer bookkeeping and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            req_cnt_q  <= '0;
            word_cnt_q <= '0;
            fd_q       <= '0;
        end else begin
            inflight_q <= rd_req;
            occ_q      <= occ_d;
            fd_q       <= fd_d;
            if (inflight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable && packet_rdy) begin
                        state_q    <= ST_READ;
                        req_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_req) begin
                        req_cnt_q <= req_cnt_q + 1'b1;
                    end
                    word_cnt_q <= word_cnt_d;
                    // Leave as soon as the final word is written this cycle.
                    if (word_cnt_d == PW_C) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_packet_reader.sv
// Bench for fx2_packet_reader: an incrementing-data FIFO model with one
// cycle of read latency, a scoreboard queue filled when each packet is
// launched, and a monitor that checks every FX2 write as it happens.
module tb_fx2_packet_reader;

    localparam int PW = 256;
    localparam int W  = 16;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          packet_rdy;
    logic          rd_req;
    logic [W-1:0]  din = '0;
    logic          fx2_full;
    logic [W-1:0]  fd;
    logic          slwr;
    logic          busy;
    logic          pkt_done;
    logic [CW-1:0] word_cnt;

    fx2_packet_reader #(.PACKET_WORDS(PW), .WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .packet_rdy (packet_rdy),
        .rd_req     (rd_req),
        .din        (din),
        .fx2_full   (fx2_full),
        .fd         (fd),
        .slwr       (slwr),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // FIFO model: data appears on din the cycle after rd_req.
    logic [15:0] fifo_data = 16'd0;
    int          rd_total  = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_req) begin
            din       <= fifo_data;
            fifo_data <= fifo_data + 16'd1;
            rd_total  <= rd_total + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard and monitor state.
    logic [15:0] exp_q[$];
    int          wr_pkt = 0, rd_pkt = 0;
    int          pkt_start = 0, first_rd = -1, first_wr = -1, last_dur = 0;
    logic        prev_busy = 1'b0, prev_slwr = 1'b0;
    logic [15:0] last_fd = 16'd0;

    always @(negedge clk) begin
        if (reset) begin
            wr_pkt    = 0;
            rd_pkt    = 0;
            last_fd   = 16'd0;
            prev_busy = 1'b0;
            prev_slwr = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                pkt_start = cyc;
                first_rd  = -1;
                first_wr  = -1;
                wr_pkt    = 0;
                rd_pkt    = 0;
            end
            if (fx2_full) chk("slwr_while_full", slwr, 0);
            if (rd_req) begin
                chk("occupancy_le_2", (rd_pkt - wr_pkt) <= 2, 1);
                rd_pkt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (slwr) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: got fd=%0d, expected no write", fd);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("fd_word", fd, e);
                    last_fd = e;
                end
                wr_pkt++;
                if (first_wr < 0) first_wr = cyc;
            end else if (busy) begin
                chk("fd_hold", fd, last_fd);
            end
            if (pkt_done) begin
                chk("pkt_writes", wr_pkt, PW);
                chk("pkt_reads", rd_pkt, PW);
                chk("done_after_last_wr", prev_slwr, 1);
                last_dur = cyc - pkt_start + 1;
            end
            prev_busy = busy;
            prev_slwr = slwr;
        end
    end

    // Random backpressure driver, active only during the stress phase.
    logic rand_en = 1'b0;
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            fx2_full = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input int off);
        for (int i = 0; i < PW; i++) exp_q.push_back(16'(fifo_data + off + i));
    endtask

    task automatic wait_busy(input string name);
        bit got = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy) begin
                got = 1;
                break;
            end
        end
        chk({name, "_start"}, got, 1);
    endtask

    task automatic wait_wc(input string name, input int w);
        bit got = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (word_cnt == CW'(w)) begin
                got = 1;
                break;
            end
        end
        chk({name, "_reach_word"}, got, 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pkt_done) begin
                got = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, got, 1);
        tick();
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_rd_req"}, rd_req, 0);
        chk({name, "_slwr"}, slwr, 0);
        chk({name, "_fd"}, fd, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_pkt_done"}, pkt_done, 0);
        chk({name, "_word_cnt"}, word_cnt, 0);
    endtask

    initial begin
        int cnt;
        int base_rd;
        int rd_at_reset;

        reset      = 1'b1;
        enable     = 1'b0;
        packet_rdy = 1'b0;
        fx2_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");

        // 1: single packet, no backpressure.
        tick();
        enable = 1'b1;
        push_pkt(0);
        packet_rdy = 1'b1;
        wait_busy("t1");
        packet_rdy = 1'b0;
        chk("t1_wc_start", word_cnt, 0);
        wait_done("t1", 2000);
        chk("t1_wr_latency", first_wr - first_rd, 2);
        chk("t1_rd_first_cycle", first_rd, pkt_start);
        chk("t1_duration", last_dur, PW + 3);
        $display("t1 single packet done, %0d vectors so far", n_vec);

        // 2: backpressure burst at word 100, single-cycle stalls at 150 and 151.
        push_pkt(0);
        packet_rdy = 1'b1;
        wait_busy("t2");
        packet_rdy = 1'b0;
        wait_wc("t2_100", 100);
        fx2_full = 1'b1;
        repeat (5) tick();
        fx2_full = 1'b0;
        wait_wc("t2_150", 150);
        fx2_full = 1'b1;
        tick();
        fx2_full = 1'b0;
        wait_wc("t2_151", 151);
        fx2_full = 1'b1;
        tick();
        fx2_full = 1'b0;
        wait_done("t2", 2000);
        $display("t2 backpressure packet done, %0d vectors so far", n_vec);

        // 3: endpoint full for the first 20 READ cycles.
        fx2_full = 1'b1;
        push_pkt(0);
        packet_rdy = 1'b1;
        wait_busy("t3");
        packet_rdy = 1'b0;
        cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rd_req) cnt++;
        end
        chk("t3_stall_reads", cnt, 2);
        tick();
        fx2_full = 1'b0;
        wait_done("t3", 2000);
        $display("t3 start stall packet done, %0d vectors so far", n_vec);

        // 4: reset mid-packet at word 77, then a fresh packet.
        push_pkt(0);
        base_rd = rd_total;
        packet_rdy = 1'b1;
        wait_busy("t4");
        packet_rdy = 1'b0;
        wait_wc("t4_77", 77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_at_reset = rd_total;
        chk("t4_aborted_reads_ge_78", (rd_at_reset - base_rd) >= 78, 1);
        @(negedge clk);
        chk_idle_outputs("t4_after_reset");
        exp_q.delete();
        repeat (5) tick();
        chk("t4_no_reads_after_reset", rd_total, rd_at_reset);
        push_pkt(0);
        packet_rdy = 1'b1;
        wait_busy("t4b");
        packet_rdy = 1'b0;
        chk("t4_restart_wc", word_cnt, 0);
        wait_done("t4b", 2000);
        $display("t4 reset abort and restart done, %0d vectors so far", n_vec);

        // 5: back-to-back packets, enable dropped during the second.
        push_pkt(0);
        push_pkt(PW);
        packet_rdy = 1'b1;
        wait_done("t5a", 2000);
        chk("t5_idle_gap", busy, 0);
        tick();
        chk("t5_back_to_back", busy, 1);
        wait_wc("t5_10", 10);
        enable = 1'b0;
        wait_done("t5b", 2000);
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (busy) cnt++;
        end
        chk("t5_no_start_disabled", cnt, 0);
        push_pkt(0);
        enable = 1'b1;
        tick();
        chk("t5_resume", busy, 1);
        packet_rdy = 1'b0;
        wait_done("t5c", 2000);
        $display("t5 back-to-back and enable done, %0d vectors so far", n_vec);

        // 6: random backpressure over 10 packets.
        rand_en = 1'b1;
        for (int p = 0; p < 10; p++) begin
            push_pkt(0);
            packet_rdy = 1'b1;
            wait_busy("t6");
            packet_rdy = 1'b0;
            wait_done("t6", 5000);
        end
        @(posedge clk);
        rand_en = 1'b0;
        #2;
        fx2_full = 1'b0;
        $display("t6 random stress done, %0d vectors so far", n_vec);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
